// File: rtl/phys_free_list_pkg.sv
// Shared widths, tag/pointer types and a popcount helper for the rename free list.
// Pure declarations: no logic, no latency, no flow control.
`timescale 1ns/1ps
package phys_free_list_pkg;

  function automatic int preg_w_f(input int num_phys_regs);
    return $clog2(num_phys_regs);
  endfunction

  // One extra pointer bit carries the wrap flag that separates full from empty.
  function automatic int ptr_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ckpt_w_f(input int num_ckpt);
    return (num_ckpt > 1) ? $clog2(num_ckpt) : 1;
  endfunction

  localparam int DEF_PREG_W = preg_w_f(64);
  localparam int DEF_PTR_W  = ptr_w_f(32);
  localparam int DEF_CKPT_W = ckpt_w_f(4);

  typedef logic [DEF_PREG_W-1:0] preg_t;
  typedef logic [DEF_PTR_W-1:0]  ptr_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += {31'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/fl_ckpt_table.sv
// Head-pointer checkpoint slots: one write port, one combinational read port.
// Write lands on the next edge; read has zero latency; never stalls.
`timescale 1ns/1ps
module fl_ckpt_table #(
  parameter int NUM_CKPT = 4,
  parameter int PTR_W    = 6,
  parameter int CKPT_W   = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              we_i,
  input  logic [CKPT_W-1:0] waddr_i,
  input  logic [PTR_W-1:0]  wdata_i,
  input  logic [CKPT_W-1:0] raddr_i,
  output logic [PTR_W-1:0]  rdata_o
);

  logic [PTR_W-1:0] slot_q [NUM_CKPT];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
    end else if (we_i) begin
      slot_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = slot_q[raddr_i];

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical tags: multi-lane allocate/free with head checkpoints.
// Outputs are combinational from state; updates land next edge; allocation is all-or-nothing on alloc_ready_o.
`timescale 1ns/1ps
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int ALLOC_W       = 2,
  parameter int FREE_W        = 2,
  parameter int NUM_CKPT      = 4,
  localparam int PREG_W       = preg_w_f(NUM_PHYS_REGS),
  localparam int PTR_W        = ptr_w_f(DEPTH),
  localparam int CKPT_W       = ckpt_w_f(NUM_CKPT)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [ALLOC_W-1:0]        alloc_req_i,
  output logic                      alloc_ready_o,
  output logic [ALLOC_W*PREG_W-1:0] alloc_addr_o,
  input  logic [FREE_W-1:0]         free_en_i,
  input  logic [FREE_W*PREG_W-1:0]  free_addr_i,
  input  logic                      ckpt_save_i,
  input  logic [CKPT_W-1:0]         ckpt_id_i,
  input  logic                      ckpt_restore_i,
  input  logic [CKPT_W-1:0]         restore_id_i,
  output logic [PTR_W-1:0]          free_count_o,
  output logic                      empty_o,
  output logic                      overflow_err_o
);

  localparam int IDX_W = PTR_W - 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, count, head_alloc, ckpt_head;
  logic [PTR_W-1:0]  n_alloc, n_free;
  logic [PTR_W:0]    count_after_free;
  logic              alloc_fire, free_ok;

  assign count         = tail_q - head_q;
  assign free_count_o  = count;
  assign empty_o       = (count == '0);
  assign alloc_ready_o = (count >= PTR_W'(ALLOC_W));

  assign n_alloc    = PTR_W'(popcount(32'(alloc_req_i)));
  assign n_free     = PTR_W'(popcount(32'(free_en_i)));
  assign alloc_fire = (|alloc_req_i) && alloc_ready_o && !ckpt_restore_i;
  assign head_alloc = alloc_fire ? head_q + n_alloc : head_q;

  // Overflow is judged against the pre-update count so a bad group is dropped whole.
  assign count_after_free = {1'b0, count} + {1'b0, n_free};
  assign free_ok          = (count_after_free <= (PTR_W+1)'(DEPTH));

  always_comb begin
    alloc_addr_o = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_addr_o[k*PREG_W +: PREG_W] = mem_q[IDX_W'(head_q + PTR_W'(k))];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PREG_W'(NUM_ARCH_REGS + i);
      head_q         <= '0;
      tail_q         <= PTR_W'(DEPTH);
      overflow_err_o <= 1'b0;
    end else begin
      head_q <= ckpt_restore_i ? ckpt_head : head_alloc;
      if (free_ok) begin
        for (int k = 0; k < FREE_W; k++) begin
          if (free_en_i[k]) mem_q[IDX_W'(tail_q + PTR_W'(k))] <= free_addr_i[k*PREG_W +: PREG_W];
        end
        tail_q <= tail_q + n_free;
      end else begin
        overflow_err_o <= 1'b1;
      end
    end
  end

  fl_ckpt_table #(
    .NUM_CKPT (NUM_CKPT),
    .PTR_W    (PTR_W),
    .CKPT_W   (CKPT_W)
  ) u_ckpt_table (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .we_i     (ckpt_save_i && !ckpt_restore_i),
    .waddr_i  (ckpt_id_i),
    .wdata_i  (head_alloc),
    .raddr_i  (restore_id_i),
    .rdata_o  (ckpt_head)
  );

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Parametrised physical-register free list for the rename stage: a circular buffer of free physical register tags, popped by rename (up to ALLOC_W per cycle) and pushed by commit (up to FREE_W per cycle). It adds multi-lane allocate/free, a free-count output, and NUM_CKPT head-pointer checkpoints so branch recovery returns speculatively allocated tags in one cycle. It sits between rename and the ROB commit path.

## Interface
- NUM_PHYS_REGS, 64, total physical registers; PREG_W = clog2(NUM_PHYS_REGS)
- NUM_ARCH_REGS, 32, architectural registers, identity-mapped at reset
- DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS, list capacity; must be a power of two, ≥ max(ALLOC_W, FREE_W)
- ALLOC_W, 2, allocate lanes
- FREE_W, 2, free lanes
- NUM_CKPT, 4, checkpoint slots; CKPT_W = clog2(NUM_CKPT)
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- alloc_req_i  in  ALLOC_W  per-lane allocate request; lanes contiguous from lane 0
- alloc_ready_o  out  1  free_count ≥ ALLOC_W
- alloc_addr_o  out  ALLOC_W*PREG_W  lane k = entry[head+k]
- free_en_i  in  FREE_W  per-lane free; lanes contiguous from lane 0
- free_addr_i  in  FREE_W*PREG_W  tags being freed
- ckpt_save_i  in  1  snapshot head into slot ckpt_id_i
- ckpt_id_i  in  CKPT_W  save slot
- ckpt_restore_i  in  1  restore head from slot restore_id_i
- restore_id_i  in  CKPT_W  restore slot
- free_count_o  out  clog2(DEPTH)+1  current free entries
- empty_o  out  1  free_count == 0
- overflow_err_o  out  1  sticky; a free group would exceed DEPTH

## Operation
- Storage: DEPTH × PREG_W entries; head/tail pointers clog2(DEPTH)+1 bits (MSB = wrap bit); free_count = tail − head modulo 2^(ptr width).
- Reset: entry[i] = NUM_ARCH_REGS+i; head = 0; tail = DEPTH (wrap bit set, index 0); all checkpoints = 0; overflow_err_o = 0.
- Allocate: fires when |alloc_req_i & alloc_ready_o & !ckpt_restore_i; head += popcount(alloc_req_i). Grant is all-or-nothing: requests while alloc_ready_o = 0 consume nothing.
- Free: n = popcount(free_en_i); lane k writes entry[tail+k]; tail += n. If free_count + n > DEPTH the whole group is discarded and overflow_err_o sets until reset.
- Checkpoint save: slot[ckpt_id_i] ← head value after this cycle's allocation.
- Restore: head ← slot[restore_id_i]; same-cycle allocation ignored; same-cycle frees still applied; same-cycle save ignored (restore wins).
- Non-contiguous alloc_req_i/free_en_i is illegal; bench asserts on it.

## Timing
- alloc_addr_o, alloc_ready_o, free_count_o, empty_o: combinational from registered state only; no bypass of same-cycle frees.
- Allocation, free, save, restore take effect at the next rising edge; freed tags visible to allocate one cycle later.
- Reset outputs: alloc_ready_o = 1, alloc_addr_o lanes = NUM_ARCH_REGS+k, free_count_o = DEPTH, empty_o = 0, overflow_err_o = 0.
- Reset asserted mid-operation clears state immediately, independent of clk_i.
- Wrap-around: pointer indices wrap modulo DEPTH; full (count = DEPTH) and empty (count = 0) differ only in the wrap bit.
- Simultaneous allocate+free at count = ALLOC_W: allocate granted (count pre-free), frees land; next count = n.

## Structure
- Shared package phys_free_list_pkg: PREG_W/PTR_W/CKPT_W localparams functions, preg_t and ptr_t typedefs, popcount function.
- One sub-module: fl_ckpt_table (NUM_CKPT × PTR_W register file, one write port, one combinational read port, async-low reset).

## Test plan
- Reset, then alloc_req_i = 2'b11 each cycle for 16 cycles -> tags 32..63 in order, free_count_o reaches 0, empty_o = 1, alloc_ready_o = 0; 17th request consumes nothing.
- From empty, free tags 5,9 in one cycle -> next cycle free_count_o = 2, alloc_addr_o = {9,5}; allocating both returns count to 0.
- Save slot 1 at count 32, allocate 6 tags over 3 cycles, restore slot 1 -> free_count_o = 32, alloc_addr_o lane 0 = the tag after the last pre-save allocation.
- Restore + alloc + free(7) in the same cycle -> allocation ignored, head from checkpoint, count = checkpoint count + 1.
- At reset (count 32), free one tag -> overflow_err_o = 1, count stays 32, entries unchanged.
- Run 200 cycles random contiguous alloc/free against a reference queue model -> every allocated tag matches, no tag ever duplicated, pointers wrap cleanly.
